// File: rtl/multicycle_adder_if.sv
// Handshake bundle for multicycle_adder: operand channel in, result channel out.
// Defining MULTICYCLE_ADDER_OVF_EN adds the Ovf result signal.
interface multicycle_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             C_out;
`ifdef MULTICYCLE_ADDER_OVF_EN
  logic             Ovf;

  modport master (
    output in_valid, A, B, C_in, out_ready,
    input  in_ready, out_valid, Sum, C_out, Ovf
  );
  modport slave (
    input  in_valid, A, B, C_in, out_ready,
    output in_ready, out_valid, Sum, C_out, Ovf
  );
`else
  modport master (
    output in_valid, A, B, C_in, out_ready,
    input  in_ready, out_valid, Sum, C_out
  );
  modport slave (
    input  in_valid, A, B, C_in, out_ready,
    output in_ready, out_valid, Sum, C_out
  );
`endif
endinterface

// File: rtl/multicycle_adder.sv
// Bit-serial-by-slice adder: adds SLICE bits per clock, WIDTH/SLICE cycles per result.
// Optional signed-overflow output enabled by defining MULTICYCLE_ADDER_OVF_EN.
module multicycle_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input logic                clk,
  input logic                rst,
  multicycle_adder_if.slave  bus
);

  localparam int unsigned N  = WIDTH / SLICE;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CW-1:0]    k_q;
  logic [WIDTH-1:0] sum_q;
  logic             c_out_q;
  logic             in_ready_q;
  logic             out_valid_q;
`ifdef MULTICYCLE_ADDER_OVF_EN
  logic             ovf_q;
`endif

  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE-1:0] slice_sum;
  logic             slice_carry;

  // Slice k of the captured operands; the loop keeps every part-select constant.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (k_q == CW'(i)) begin
        a_sl = a_q[i*SLICE +: SLICE];
        b_sl = b_q[i*SLICE +: SLICE];
      end
    end
  end

  assign {slice_carry, slice_sum} = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_q};

`ifdef MULTICYCLE_ADDER_OVF_EN
  // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
  logic msb_carry_in;
  assign msb_carry_in = slice_sum[SLICE-1] ^ a_sl[SLICE-1] ^ b_sl[SLICE-1];
`endif

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      k_q         <= '0;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef MULTICYCLE_ADDER_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.A;
            b_q        <= bus.B;
            carry_q    <= bus.C_in;
            k_q        <= '0;
            in_ready_q <= 1'b0;
            state      <= RUN;
          end
        end

        RUN: begin
          for (int i = 0; i < int'(N); i++) begin
            if (k_q == CW'(i)) sum_q[i*SLICE +: SLICE] <= slice_sum;
          end
          carry_q <= slice_carry;
          k_q     <= k_q + 1'b1;
          if (k_q == LAST) begin
            c_out_q     <= slice_carry;
            out_valid_q <= 1'b1;
            state       <= DONE;
`ifdef MULTICYCLE_ADDER_OVF_EN
            ovf_q       <= msb_carry_in ^ slice_carry;
`endif
          end
        end

        DONE: begin
          // Returning through IDLE forbids an accept on the handshake edge.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.Sum       = sum_q;
  assign bus.C_out     = c_out_q;
`ifdef MULTICYCLE_ADDER_OVF_EN
  assign bus.Ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_multicycle_adder.sv
// Directed self-checking bench for multicycle_adder (16/4 and 8/8 configurations).
// Ovf checks are compiled in when MULTICYCLE_ADDER_OVF_EN is defined.
module tb_multicycle_adder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  multicycle_adder_if #(.WIDTH(16)) bus16 ();
  multicycle_adder_if #(.WIDTH(8))  bus8 ();

  multicycle_adder #(.WIDTH(16), .SLICE(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  multicycle_adder #(.WIDTH(8),  .SLICE(8)) dut8  (.clk(clk), .rst(rst), .bus(bus8));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation on dut16 and wait for out_valid; returns edges after accept.
  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic c, output int lat);
    bus16.A = a; bus16.B = b; bus16.C_in = c; bus16.in_valid = 1'b1;
    tick();
    bus16.in_valid = 1'b0;
    lat = 0;
    while (bus16.out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic consume16();
    bus16.out_ready = 1'b1;
    tick();
    bus16.out_ready = 1'b0;
  endtask

  task automatic check_result(input string name, input int lat, input int exp_lat,
                              input logic [15:0] exp_sum, input logic exp_c);
    total++;
    if (lat !== exp_lat) begin
      bad++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    total++;
    if (bus16.Sum !== exp_sum || bus16.C_out !== exp_c) begin
      bad++;
      $display("FAIL %s result: got Sum=%h C_out=%b want Sum=%h C_out=%b",
               name, bus16.Sum, bus16.C_out, exp_sum, exp_c);
    end
  endtask

  task automatic test_reset();
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b0; bus16.A = '0; bus16.B = '0; bus16.C_in = 1'b0;
    bus8.in_valid  = 1'b0; bus8.out_ready  = 1'b0; bus8.A  = '0; bus8.B  = '0; bus8.C_in  = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (bus16.in_ready !== 1'b1 || bus16.out_valid !== 1'b0 || bus16.Sum !== 16'h0000 || bus16.C_out !== 1'b0) begin
      bad++;
      $display("FAIL reset16: got rdy=%b vld=%b Sum=%h C=%b want 1 0 0000 0",
               bus16.in_ready, bus16.out_valid, bus16.Sum, bus16.C_out);
    end
    total++;
    if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0 || bus8.Sum !== 8'h00 || bus8.C_out !== 1'b0) begin
      bad++;
      $display("FAIL reset8: got rdy=%b vld=%b Sum=%h C=%b want 1 0 00 0",
               bus8.in_ready, bus8.out_valid, bus8.Sum, bus8.C_out);
    end
  endtask

  task automatic test_latency();
    int lat;
    // Watch out_valid on each edge after accept: low for 3 edges, high on the 4th.
    bus16.A = 16'h000B; bus16.B = 16'h0007; bus16.C_in = 1'b1; bus16.in_valid = 1'b1;
    tick();
    bus16.in_valid = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      total++;
      if (bus16.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL latency_early edge %0d: got out_valid=%b want 0", e, bus16.out_valid);
      end
    end
    tick();
    lat = (bus16.out_valid === 1'b1) ? 4 : -1;
    check_result("basic_0B_07_c1", lat, 4, 16'h0013, 1'b0);
    consume16();
  endtask

  task automatic test_vectors();
    logic [15:0] va [5] = '{16'hFFFF, 16'h1234, 16'h8000, 16'hFFFF, 16'h0F0F};
    logic [15:0] vb [5] = '{16'h0001, 16'h4321, 16'h8000, 16'hFFFF, 16'h00F1};
    logic        vc [5] = '{1'b0,     1'b0,     1'b1,     1'b1,     1'b0};
    logic [15:0] es [5] = '{16'h0000, 16'h5555, 16'h0001, 16'hFFFF, 16'h1000};
    logic        ec [5] = '{1'b1,     1'b0,     1'b1,     1'b1,     1'b0};
    int lat;
    for (int i = 0; i < 5; i++) begin
      run16(va[i], vb[i], vc[i], lat);
      check_result($sformatf("vec%0d", i), lat, 4, es[i], ec[i]);
      consume16();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    run16(16'h00AA, 16'h0055, 1'b0, lat);
    check_result("bp_first", lat, 4, 16'h00FF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus16.A = 16'h1357 ^ 16'(i * 16'h1111);
      bus16.B = ~bus16.A;
      bus16.C_in = i[0];
      bus16.in_valid = 1'b1;
      bus16.out_ready = 1'b0;
      tick();
      total++;
      if (bus16.out_valid !== 1'b1 || bus16.in_ready !== 1'b0 || bus16.Sum !== 16'h00FF || bus16.C_out !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold cycle %0d: got vld=%b rdy=%b Sum=%h C=%b want 1 0 00FF 0",
                 i, bus16.out_valid, bus16.in_ready, bus16.Sum, bus16.C_out);
      end
    end
    bus16.A = 16'h0100; bus16.B = 16'h0200; bus16.C_in = 1'b0;
    bus16.out_ready = 1'b1;
    tick();
    bus16.out_ready = 1'b0;
    total++;
    if (bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: got vld=%b rdy=%b want 0 1", bus16.out_valid, bus16.in_ready);
    end
    tick();
    bus16.in_valid = 1'b0;
    total++;
    if (bus16.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_next_accept: got in_ready=%b want 0", bus16.in_ready);
    end
    lat = 0;
    while (bus16.out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check_result("bp_second", lat, 4, 16'h0300, 1'b0);
    consume16();
  endtask

  task automatic test_reset_mid_run();
    bit seen = 0;
    bus16.A = 16'h1111; bus16.B = 16'h2222; bus16.C_in = 1'b1; bus16.in_valid = 1'b1;
    tick();
    bus16.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (bus16.Sum !== 16'h0000 || bus16.C_out !== 1'b0 || bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_run: got Sum=%h C=%b vld=%b rdy=%b want 0000 0 0 1",
               bus16.Sum, bus16.C_out, bus16.out_valid, bus16.in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus16.out_valid !== 1'b0) seen = 1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL rst_no_result: got out_valid=1 after reset want 0");
    end
  endtask

  task automatic test_single_slice();
    int lat = 0;
    bus8.A = 8'hB0; bus8.B = 8'h70; bus8.C_in = 1'b1; bus8.in_valid = 1'b1;
    tick();
    bus8.in_valid = 1'b0;
    while (bus8.out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    total++;
    if (lat !== 1 || bus8.Sum !== 8'h21 || bus8.C_out !== 1'b1) begin
      bad++;
      $display("FAIL n1_B0_70: got lat=%0d Sum=%h C=%b want 1 21 1", lat, bus8.Sum, bus8.C_out);
    end
    bus8.out_ready = 1'b1;
    tick();
    bus8.out_ready = 1'b0;
    total++;
    if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL n1_release: got vld=%b rdy=%b want 0 1", bus8.out_valid, bus8.in_ready);
    end
  endtask

`ifdef MULTICYCLE_ADDER_OVF_EN
  task automatic test_ovf();
    int lat;
    run16(16'h7FFF, 16'h0001, 1'b0, lat);
    check_result("ovf_7FFF", lat, 4, 16'h8000, 1'b0);
    total++;
    if (bus16.Ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_set: got Ovf=%b want 1", bus16.Ovf);
    end
    consume16();
    run16(16'hFFFF, 16'h0001, 1'b0, lat);
    check_result("ovf_FFFF", lat, 4, 16'h0000, 1'b1);
    total++;
    if (bus16.Ovf !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear: got Ovf=%b want 0", bus16.Ovf);
    end
    consume16();
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_backpressure();
    test_reset_mid_run();
    test_single_slice();
`ifdef MULTICYCLE_ADDER_OVF_EN
    test_ovf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_adder.md
MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, operand and sum width in bits.
REQ-002 SHALL provide parameter SLICE, default 4, bits added per clock cycle; WIDTH SHALL be an integer multiple of SLICE (N = WIDTH/SLICE).
REQ-003 SHALL provide port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL provide port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 SHALL provide port in_valid  input  1  operands A, B, C_in are valid.
REQ-006 SHALL provide port in_ready  output  1  block can accept operands.
REQ-007 SHALL provide port A  input  WIDTH  unsigned addend.
REQ-008 SHALL provide port B  input  WIDTH  unsigned addend.
REQ-009 SHALL provide port C_in  input  1  carry into bit 0.
REQ-010 SHALL provide port out_valid  output  1  Sum/C_out hold a completed result.
REQ-011 SHALL provide port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL provide port Sum  output  WIDTH  registered result, low WIDTH bits of A+B+C_in.
REQ-013 SHALL provide port C_out  output  1  carry out of bit WIDTH-1.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; in_ready = 1 only in IDLE, out_valid = 1 only in DONE.
REQ-015 Input accept SHALL occur on a rising edge with in_valid && in_ready; A, B, C_in are captured into internal registers, slice counter cleared, state -> RUN.
REQ-016 Inputs SHALL be ignored outside the accept edge; changes to A/B/C_in during RUN/DONE have no effect.
REQ-017 In RUN, each edge SHALL add slice k (bits k*SLICE+SLICE-1 : k*SLICE) of the captured operands plus the registered carry, write that slice of Sum, register the slice carry, and increment k.
REQ-018 The carry into slice 0 SHALL be the captured C_in.
REQ-019 On the RUN edge processing slice N-1, state SHALL -> DONE and C_out SHALL take that slice's carry.
REQ-020 Latency SHALL be exactly N edges: accept at edge t, out_valid = 1 after edge t+N (WIDTH=16, SLICE=4: 4 edges).
REQ-021 In DONE, Sum, C_out (and Ovf if present) SHALL be held stable until an edge with out_ready = 1, then state -> IDLE.
REQ-022 A new accept SHALL NOT occur on the same edge as the out_ready handshake; earliest next accept is the following edge (throughput one result per N+2 cycles).
REQ-023 in_valid during RUN or DONE SHALL be held off (in_ready = 0); no operand is dropped or overwritten.
REQ-024 Result SHALL equal {C_out, Sum} = A + B + C_in computed at WIDTH+1 bits, for all operand values including all-ones wrap-around.
REQ-025 SLICE = WIDTH (N = 1) SHALL be legal: single RUN cycle, latency 1.

Reset
REQ-026 On an edge with rst = 1, state SHALL -> IDLE, Sum = 0, C_out = 0, internal carry = 0, slice counter = 0, Ovf = 0 if present; out_valid = 0, in_ready = 1 after that edge.
REQ-027 rst SHALL take priority over any handshake on the same edge; rst mid-RUN or in DONE SHALL discard the pending operation with no result issued.

Configuration
REQ-028 Macro MULTICYCLE_ADDER_OVF_EN defined: SHALL add output port Ovf (1 bit) = signed two's-complement overflow = carry into bit WIDTH-1 XOR C_out, updated on the slice N-1 edge, held in DONE like Sum.
REQ-029 Macro MULTICYCLE_ADDER_OVF_EN undefined: Ovf port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-030 WIDTH=16, SLICE=4: A=0x000B, B=0x0007, C_in=1 accepted at edge 0 -> out_valid after edge 4, Sum=0x0013, C_out=0.
REQ-031 A=0xFFFF, B=0x0001, C_in=0 -> Sum=0x0000, C_out=1 (carry ripples through all 4 slices).
REQ-032 Result ready, out_ready held 0 for 5 cycles while A/B toggle and in_valid=1 -> Sum/C_out stable, in_ready=0; out_ready=1 -> IDLE next edge, then new operand accepted.
REQ-033 rst=1 asserted at slice 2 of RUN -> next edge Sum=0, C_out=0, out_valid=0, in_ready=1; no result ever presented for that operation.
REQ-034 MULTICYCLE_ADDER_OVF_EN defined: A=0x7FFF, B=0x0001, C_in=0 -> Sum=0x8000, C_out=0, Ovf=1; A=0xFFFF, B=0x0001 -> Ovf=0.
REQ-035 WIDTH=8, SLICE=8: A=0xB0, B=0x70, C_in=1 -> out_valid after 1 edge, Sum=0x21, C_out=1.
